// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: direct-mapped table of tagged 2-bit saturating
// counters with branch targets. Lookup at fetch is combinational; training
// comes from execute and raises a registered redirect on a wrong prediction.
// Optional resolved/mispredict statistics are built when BPU_STATS_EN is defined.
module branch_predictor_unit #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ENTRIES   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DataWidth-1:0] fetch_pc,
  output logic                 pred_taken,
  output logic [DataWidth-1:0] pred_target,
  input  logic                 upd_valid,
  input  logic [DataWidth-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [DataWidth-1:0] upd_target,
  input  logic                 upd_pred_taken,
  input  logic [DataWidth-1:0] upd_pred_target,
  output logic                 mispredict,
  output logic [DataWidth-1:0] redirect_pc,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TAG = DataWidth - 2 - IDX;

  logic                 valid_q  [ENTRIES];
  logic [TAG-1:0]       tag_q    [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [DataWidth-1:0] target_q [ENTRIES];

  logic [IDX-1:0]       fetch_idx;
  logic [TAG-1:0]       fetch_tag;
  logic                 fetch_hit;
  logic [IDX-1:0]       upd_idx;
  logic [TAG-1:0]       upd_tag;
  logic                 upd_hit;
  logic [1:0]           upd_ctr;
  logic                 mis_cond;
  logic [DataWidth-1:0] redirect_d;
  logic                 mispredict_q;
  logic [DataWidth-1:0] redirect_q;

  // Word-alignment bits never affect indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign fetch_idx = fetch_pc[IDX+1:2];
  assign fetch_tag = fetch_pc[DataWidth-1:IDX+2];
  assign upd_idx   = upd_pc[IDX+1:2];
  assign upd_tag   = upd_pc[DataWidth-1:IDX+2];

  // Fetch lookup reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + DataWidth'(4);
  end

  // Saturating counter step and mispredict/redirect decode for the resolving branch.
  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr = ctr_q[upd_idx];
    if (upd_taken) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr = ctr_q[upd_idx] - 2'd1;
    end
    mis_cond   = (upd_taken != upd_pred_taken) ||
                 (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
    redirect_d = upd_taken ? upd_target : upd_pc + DataWidth'(4);
  end

  // Table training; a taken miss evicts whatever tag held the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr;
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        ctr_q[upd_idx]    <= 2'b10;
        target_q[upd_idx] <= upd_target;
      end
    end
  end

  // One-cycle flush pulse; redirect target holds between updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= upd_valid && mis_cond;
      if (upd_valid) redirect_q <= redirect_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  // Free-running wrapping event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (upd_valid) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (mis_cond) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit: a table of update/lookup vectors
// followed by hand-written multi-cycle sequences (hold, no-bypass, ordering,
// async reset, statistics).
module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = 32'h0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int errors = 0;
  int checks = 0;

  branch_predictor_unit #(.DataWidth(32), .ENTRIES(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    logic        exp_mis;
    logic [31:0] exp_redir;
    logic [31:0] look_pc;
    logic        exp_pt;
    logic [31:0] exp_ptgt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one update for exactly one rising edge; returns 1 time unit after that edge.
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    @(negedge clk);
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tg;
    upd_pred_taken  = pt;
    upd_pred_target = ptg;
    upd_valid       = 1'b1;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    // pc, taken, tgt, ptaken, ptgt, exp_mis, exp_redir, look_pc, exp_pt, exp_ptgt
    vecs[0]  = '{32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80, 32'h100, 1'b1, 32'h80};
    vecs[1]  = '{32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80, 32'h100, 1'b1, 32'h80};
    vecs[2]  = '{32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80, 32'h100, 1'b1, 32'h80};
    vecs[3]  = '{32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80, 32'h100, 1'b1, 32'h80};
    vecs[4]  = '{32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104, 32'h100, 1'b1, 32'h80};
    vecs[5]  = '{32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104, 32'h100, 1'b0, 32'h104};
    vecs[6]  = '{32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80, 32'h100, 1'b1, 32'h80};
    vecs[7]  = '{32'h140, 1'b1, 32'h200, 1'b0, 32'h144, 1'b1, 32'h200, 32'h100, 1'b0, 32'h104};
    vecs[8]  = '{32'h300, 1'b0, 32'h0, 1'b0, 32'h304, 1'b0, 32'h304, 32'h140, 1'b1, 32'h200};
    vecs[9]  = '{32'hFFFFFFFC, 1'b0, 32'h1234, 1'b1, 32'h40, 1'b1, 32'h0,
                 32'hFFFFFFFC, 1'b0, 32'h0};
    vecs[10] = '{32'h20, 1'b1, 32'h40, 1'b1, 32'h44, 1'b1, 32'h40, 32'h20, 1'b1, 32'h40};
    vecs[11] = '{32'h20, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40, 32'h22, 1'b1, 32'h40};
    vecs[12] = '{32'h20, 1'b1, 32'h60, 1'b1, 32'h40, 1'b1, 32'h60, 32'h20, 1'b1, 32'h60};
    vecs[13] = '{32'h20, 1'b0, 32'h60, 1'b0, 32'h24, 1'b0, 32'h24, 32'h20, 1'b1, 32'h60};

    // Reset state
    fetch_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check("reset pred_taken", {31'b0, pred_taken}, 32'h0);
    check("reset pred_target", pred_target, 32'h104);
    check("reset mispredict", {31'b0, mispredict}, 32'h0);
    check("reset redirect_pc", redirect_pc, 32'h0);
    check("reset stat_branches", stat_branches, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      upd(vecs[i].pc, vecs[i].taken, vecs[i].tgt, vecs[i].ptaken, vecs[i].ptgt);
      check($sformatf("v%0d mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].exp_mis});
      check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].exp_redir);
      fetch_pc = vecs[i].look_pc;
      #1;
      check($sformatf("v%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].exp_pt});
      check($sformatf("v%0d pred_target", i), pred_target, vecs[i].exp_ptgt);
    end

    // Mispredict pulses once; idle cycle clears it and redirect holds
    upd(32'h3C0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("pulse mispredict", {31'b0, mispredict}, 32'h1);
    check("pulse redirect_pc", redirect_pc, 32'h3C4);
    @(posedge clk);
    #1;
    check("idle mispredict", {31'b0, mispredict}, 32'h0);
    check("idle redirect_pc", redirect_pc, 32'h3C4);

    // Same-cycle lookup and update at one index: lookup sees pre-update entry
    @(negedge clk);
    fetch_pc        = 32'h140;
    upd_pc          = 32'h140;
    upd_taken       = 1'b0;
    upd_target      = 32'h0;
    upd_pred_taken  = 1'b1;
    upd_pred_target = 32'h200;
    upd_valid       = 1'b1;
    #1;
    check("nobypass pred_taken", {31'b0, pred_taken}, 32'h1);
    check("nobypass pred_target", pred_target, 32'h200);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    check("after upd pred_taken", {31'b0, pred_taken}, 32'h0);
    check("after upd pred_target", pred_target, 32'h144);

    // Back-to-back updates, same index, applied in order: 01 -> 10 -> 11 -> 10
    upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    upd(32'h140, 1'b1, 32'h200, 1'b1, 32'h200);
    upd(32'h140, 1'b0, 32'h200, 1'b1, 32'h200);
    #1;
    check("b2b pred_taken", {31'b0, pred_taken}, 32'h1);
    check("b2b pred_target", pred_target, 32'h200);

    // Asynchronous reset while a mispredict is pending
    upd(32'h140, 1'b0, 32'h0, 1'b1, 32'h200);
    check("pending mispredict", {31'b0, mispredict}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async mispredict", {31'b0, mispredict}, 32'h0);
    check("async redirect_pc", redirect_pc, 32'h0);
    check("async stat_branches", stat_branches, 32'h0);
    check("async stat_mispredicts", stat_mispredicts, 32'h0);
    check("async pred_taken", {31'b0, pred_taken}, 32'h0);
    check("async pred_target", pred_target, 32'h144);
    fetch_pc = 32'h20;
    #1;
    check("async empty 0x20", {31'b0, pred_taken}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Statistics: 10 updates, 3 mispredicts, with an idle cycle in the middle
    for (int i = 0; i < 10; i++) begin
      upd(32'h400, 1'b0, 32'h0, ((i % 3) == 0) && (i < 9), 32'h404);
      if (i == 4) @(posedge clk);
    end
    @(posedge clk);
    #1;
`ifdef BPU_STATS_EN
    check("stat_branches", stat_branches, 32'd10);
    check("stat_mispredicts", stat_mispredicts, 32'd3);
`else
    check("stat_branches off", stat_branches, 32'd0);
    check("stat_mispredicts off", stat_mispredicts, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
